// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/DM requesters, the arbiter and the unified memory.
// slave  : arbiter view (requests and memory read data in, memory strobes and completions out)
// master : requester/memory view (the opposite directions)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction-fetch and data-memory accesses onto
// one single-port synchronous memory with a fixed MEM_LAT read latency.
// Each access: grant in IDLE, one mem_en cycle, wait MEM_LAT, one ready pulse.
// DM has priority over IF. Optional macro ARB_STARVE_GUARD_EN forces an IF
// grant after STARVE_MAX consecutive contested DM grants.
// All outputs are registered; reset is synchronous active-high.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               cclk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        owner_dm_q;
  logic        store_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ready_q;
  logic        dm_ready_q;
  logic        busy_q;
  logic        grant_dm_d;
  logic        grant_if_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q;
`else
  // Starvation limit has no effect with strict DM priority.
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
`endif

  // Grant decision for the IDLE cycle: DM (older instruction) first.
  always_comb begin
    grant_dm_d = bus.dm_req;
    grant_if_d = bus.if_req & ~bus.dm_req;
`ifdef ARB_STARVE_GUARD_EN
    if (bus.dm_req && bus.if_req && (starve_q == STARVE_LIM)) begin
      grant_dm_d = 1'b0;
      grant_if_d = 1'b1;
    end
`endif
  end

  // Access sequencer: IDLE -> ACCESS (MEM_LAT+1 cycles) -> RESP -> IDLE.
  always_ff @(posedge cclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_dm_q  <= 1'b0;
      store_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      // Strobes and completion pulses last exactly one cycle.
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_dm_d || grant_if_d) begin
            owner_dm_q  <= grant_dm_d;
            store_q     <= grant_dm_d & bus.dm_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_dm_d & bus.dm_we;
            mem_addr_q  <= grant_dm_d ? bus.dm_addr : bus.if_addr;
            mem_wdata_q <= grant_dm_d ? bus.dm_wdata : 32'h0;
            cnt_q       <= LAT_LOAD;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
`ifdef ARB_STARVE_GUARD_EN
            if (grant_if_d)       starve_q <= '0;
            else if (bus.if_req)  starve_q <= starve_q + 4'd1;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (owner_dm_q) begin
              if (!store_q) dm_rdata_q <= bus.mem_rdata;
              dm_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= bus.mem_rdata;
              if_ready_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LAT = 2, 1, 15, each
// with a memory model that returns data only in the cycle it is due.
module tb_mem_port_arbiter;

  localparam int LATS [3] = '{2, 1, 15};

  logic        cclk;
  logic        reset;
  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        dm_req    [3];
  logic        dm_we     [3];
  logic [31:0] dm_addr   [3];
  logic [31:0] dm_wdata  [3];
  logic [31:0] if_rdata  [3];
  logic        if_ready  [3];
  logic [31:0] dm_rdata  [3];
  logic        dm_ready  [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic        busy      [3];

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'h2008000A;
    return {~a[15:0], a[15:0]};
  endfunction

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter_if bus ();
    int          lat_cnt;
    logic [31:0] addr_q;

    assign bus.if_req   = if_req[g];
    assign bus.if_addr  = if_addr[g];
    assign bus.dm_req   = dm_req[g];
    assign bus.dm_we    = dm_we[g];
    assign bus.dm_addr  = dm_addr[g];
    assign bus.dm_wdata = dm_wdata[g];
    assign if_rdata[g]  = bus.if_rdata;
    assign if_ready[g]  = bus.if_ready;
    assign dm_rdata[g]  = bus.dm_rdata;
    assign dm_ready[g]  = bus.dm_ready;
    assign mem_en[g]    = bus.mem_en;
    assign mem_we[g]    = bus.mem_we;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_wdata[g] = bus.mem_wdata;
    assign busy[g]      = bus.busy;

    // Memory: read data is valid only MEM_LAT cycles after the mem_en cycle.
    always @(posedge cclk) begin
      if (reset) begin
        lat_cnt <= 0;
      end else if (bus.mem_en) begin
        lat_cnt <= LATS[g];
        addr_q  <= bus.mem_addr;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
      end
    end
    assign bus.mem_rdata = (lat_cnt == 1) ? memval(addr_q) : 32'hBADBAD00;

    mem_port_arbiter #(.MEM_LAT(LATS[g]), .STARVE_MAX(4)) u_dut (
      .cclk  (cclk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t vt [7];

  int          en_cyc_q [$];
  logic [31:0] en_addr_q[$];
  int          ifr_q    [$];
  logic [31:0] ifd_q    [$];
  int          dmr_q    [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    en_cyc_q.delete();
    en_addr_q.delete();
    ifr_q.delete();
    ifd_q.delete();
    dmr_q.delete();
  endtask

  // Log grants and completions for ncyc cycles; hold keeps requests raised
  // (IF steps its address by 4 after each completion).
  task automatic run_log(input int k, input int ncyc, input bit hold);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge cclk);
      if (mem_en[k]) begin
        en_cyc_q.push_back(c);
        en_addr_q.push_back(mem_addr[k]);
      end
      if (if_ready[k]) begin
        ifr_q.push_back(c);
        ifd_q.push_back(if_rdata[k]);
        if (hold) if_addr[k] = if_addr[k] + 32'd4;
        else      if_req[k]  = 1'b0;
      end
      if (dm_ready[k]) begin
        dmr_q.push_back(c);
        if (!hold) dm_req[k] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] qint(input int q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qlog(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  // One isolated transaction on instance k, started from IDLE.
  task automatic do_txn(input int k, input vec_t v);
    int   n      = 0;
    int   en_c   = -1;
    int   rdy_c  = -1;
    int   en_cnt = 0;
    logic rdy;
    logic other;
    if (v.dm) begin
      dm_req[k]   = 1'b1;
      dm_we[k]    = v.we;
      dm_addr[k]  = v.addr;
      dm_wdata[k] = v.wdata;
    end else begin
      if_req[k]   = 1'b1;
      if_addr[k]  = v.addr;
      dm_wdata[k] = 32'hCAFEF00D;
    end
    while (rdy_c < 0 && n < 60) begin
      @(negedge cclk);
      n++;
      if (mem_en[k]) begin
        en_cnt++;
        if (en_c < 0) begin
          en_c = n;
          chk("grant_addr",  mem_addr[k], v.addr);
          chk("grant_we",    32'(mem_we[k]), 32'(v.dm & v.we));
          chk("grant_wdata", mem_wdata[k], v.dm ? v.wdata : 32'h0);
          chk("grant_busy",  32'(busy[k]), 32'd1);
        end
      end else if (en_c > 0 && n == en_c + 1) begin
        chk("we_falls", 32'(mem_we[k]), 32'd0);
      end
      rdy   = v.dm ? dm_ready[k] : if_ready[k];
      other = v.dm ? if_ready[k] : dm_ready[k];
      if (rdy) begin
        rdy_c = n;
        chk("other_ready", 32'(other), 32'd0);
        chk("resp_busy",   32'(busy[k]), 32'd1);
      end
    end
    if (rdy_c < 0) begin
      chk("ready_timeout", 32'(n), 32'd0);
    end else begin
      chk("ready_latency", 32'(rdy_c - en_c), 32'(LATS[k] + 1));
      chk("en_count",      32'(en_cnt), 32'd1);
    end
    if_req[k] = 1'b0;
    dm_req[k] = 1'b0;
    dm_we[k]  = 1'b0;
    @(negedge cclk);
    chk("post_if_ready", 32'(if_ready[k]), 32'd0);
    chk("post_dm_ready", 32'(dm_ready[k]), 32'd0);
    chk("post_busy",     32'(busy[k]), 32'd0);
    chk("if_rdata",      if_rdata[k], v.exp_if);
    chk("dm_rdata",      dm_rdata[k], v.exp_dm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{dm:0, we:0, addr:32'h0000_0010, wdata:32'h0,         exp_if:32'h2008_000A, exp_dm:32'h0};
    vt[1] = '{dm:1, we:0, addr:32'h0000_0040, wdata:32'hA5A5_A5A5, exp_if:32'h2008_000A, exp_dm:32'hFFBF_0040};
    vt[2] = '{dm:1, we:1, addr:32'h0000_0044, wdata:32'hDEAD_BEEF, exp_if:32'h2008_000A, exp_dm:32'hFFBF_0040};
    vt[3] = '{dm:0, we:0, addr:32'h0000_0014, wdata:32'h0,         exp_if:32'hFFEB_0014, exp_dm:32'hFFBF_0040};
    vt[4] = '{dm:1, we:0, addr:32'h0000_1234, wdata:32'h0,         exp_if:32'hFFEB_0014, exp_dm:32'hEDCB_1234};
    vt[5] = '{dm:1, we:1, addr:32'h0000_0008, wdata:32'h1234_5678, exp_if:32'hFFEB_0014, exp_dm:32'hEDCB_1234};
    vt[6] = '{dm:0, we:0, addr:32'hFFFF_FFFC, wdata:32'h0,         exp_if:32'h0003_FFFC, exp_dm:32'hEDCB_1234};

    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge cclk);
    chk("rst_mem_en",    32'(mem_en[0]), 32'd0);
    chk("rst_mem_we",    32'(mem_we[0]), 32'd0);
    chk("rst_mem_addr",  mem_addr[0], 32'd0);
    chk("rst_mem_wdata", mem_wdata[0], 32'd0);
    chk("rst_if_ready",  32'(if_ready[0]), 32'd0);
    chk("rst_dm_ready",  32'(dm_ready[0]), 32'd0);
    chk("rst_if_rdata",  if_rdata[0], 32'd0);
    chk("rst_dm_rdata",  dm_rdata[0], 32'd0);
    chk("rst_busy",      32'(busy[0]), 32'd0);
    reset = 1'b0;

    // Single-requester loads, stores and fetches on the MEM_LAT=2 instance.
    for (int i = 0; i < 7; i++) do_txn(0, vt[i]);

    // Simultaneous requests: DM first, IF in the cycle after dm_ready.
    clear_log();
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h40; dm_wdata[0] = 32'h0;
    run_log(0, 12, 1'b0);
    chk("pri_en_count",  32'(en_cyc_q.size()), 32'd2);
    chk("pri_en0_cyc",   qint(en_cyc_q, 0), 32'd1);
    chk("pri_en0_addr",  qlog(en_addr_q, 0), 32'h40);
    chk("pri_dm_ready",  qint(dmr_q, 0), 32'd4);
    chk("pri_en1_cyc",   qint(en_cyc_q, 1), 32'd6);
    chk("pri_en1_addr",  qlog(en_addr_q, 1), 32'h20);
    chk("pri_if_ready",  qint(ifr_q, 0), 32'd9);
    chk("pri_if_rdata",  qlog(ifd_q, 0), 32'hFFDF_0020);
    chk("pri_dm_rdata",  dm_rdata[0], 32'hFFBF_0040);

    // Reset in the second ACCESS cycle abandons the fetch.
    clear_log();
    @(negedge cclk);
    if_req[0] = 1'b1; if_addr[0] = 32'h30;
    @(negedge cclk);
    chk("ab_mem_en", 32'(mem_en[0]), 32'd1);
    @(negedge cclk);
    reset = 1'b1;
    if_req[0] = 1'b0;
    @(negedge cclk);
    chk("ab_mem_en_low", 32'(mem_en[0]), 32'd0);
    chk("ab_mem_addr",   mem_addr[0], 32'd0);
    chk("ab_busy",       32'(busy[0]), 32'd0);
    chk("ab_if_ready",   32'(if_ready[0]), 32'd0);
    chk("ab_if_rdata",   if_rdata[0], 32'd0);
    chk("ab_dm_rdata",   dm_rdata[0], 32'd0);
    reset = 1'b0;
    run_log(0, 8, 1'b0);
    chk("ab_no_ready", 32'(ifr_q.size() + dmr_q.size()), 32'd0);
    chk("ab_no_grant", 32'(en_cyc_q.size()), 32'd0);
    do_txn(0, '{dm:0, we:0, addr:32'h30, wdata:32'h0, exp_if:32'hFFCF_0030, exp_dm:32'h0});

    // Both requests held continuously.
    clear_log();
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h80;
    if_req[0] = 1'b1; if_addr[0] = 32'h84;
    run_log(0, 27, 1'b1);
    dm_req[0] = 1'b0;
    if_req[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("hold_en_cyc", qint(en_cyc_q, i), 32'(1 + 5 * i));
`ifdef ARB_STARVE_GUARD_EN
      chk("hold_en_addr", qlog(en_addr_q, i), (i == 4) ? 32'h84 : 32'h80);
`else
      chk("hold_en_addr", qlog(en_addr_q, i), 32'h80);
`endif
    end
    clear_log();
    run_log(0, 10, 1'b0);

    // Back-to-back fetches at the latency extremes.
    for (int k = 1; k < 3; k++) begin
      clear_log();
      if_addr[k] = 32'h100;
      if_req[k]  = 1'b1;
      run_log(k, 4 * (LATS[k] + 3) + 2, 1'b1);
      if_req[k] = 1'b0;
      chk("sweep_first_ready", qint(ifr_q, 0), 32'(LATS[k] + 2));
      for (int i = 0; i < 4; i++) begin
        chk("sweep_addr",  qlog(en_addr_q, i), 32'h100 + 32'(4 * i));
        chk("sweep_rdata", qlog(ifd_q, i), memval(32'h100 + 32'(4 * i)));
        if (i > 0)
          chk("sweep_spacing", qint(ifr_q, i) - qint(ifr_q, i - 1), 32'(LATS[k] + 3));
      end
      clear_log();
      run_log(k, LATS[k] + 5, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared single-port synchronous memory between the pipeline's instruction-fetch (IF) requester and data-memory (DM, MEM stage) requester.
- Serialises accesses, applies a fixed latency model and returns read data with a one-cycle ready pulse.
- Stalling requesters hold their request until ready arrives.
- Sits between the pipeline stage registers and the unified memory inside the MIPS top.

Parameters:
MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15 (4-bit counter).
STARVE_MAX, 4, consecutive contested DM grants before IF is forced (used only with ARB_STARVE_GUARD_EN).

Ports:
cclk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_ready
if_addr  input  32  fetch byte address
if_rdata  output  32  fetched instruction; valid when if_ready
if_ready  output  1  one-cycle completion pulse for IF
dm_req  input  1  data request; held until dm_ready
dm_we  input  1  1 = store, 0 = load
dm_addr  input  32  data byte address
dm_wdata  input  32  store data
dm_rdata  output  32  load data; valid when dm_ready
dm_ready  output  1  one-cycle completion pulse for DM
mem_en  output  1  memory access strobe, exactly one cycle per access
mem_we  output  1  memory write enable; high only together with mem_en
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port cclk, reset port reset). All outputs are registered.
- Reset values: all outputs 0. FSM = IDLE, counter = 0, starve counter = 0.
- FSM states: IDLE, ACCESS and RESP.
- IDLE, cycle G:
  - If dm_req, grant DM; else if if_req, grant IF; else stay.
  - On grant, at the edge: latch owner, drive mem_en=1, mem_we=dm_we&(owner==DM), mem_addr, mem_wdata (0 for IF). Load cnt=MEM_LAT. Go to ACCESS.
- ACCESS:
  - mem_en high in the first ACCESS cycle (G+1) only; mem_we falls with it. mem_addr and mem_wdata hold until IDLE.
  - cnt decrements each cycle. In cycle G+1+MEM_LAT (cnt==0), sample mem_rdata into the owner's rdata register and go to RESP.
- RESP, cycle G+2+MEM_LAT:
  - Owner's ready=1 for exactly this cycle, then back to IDLE.
  - Grant-to-ready latency = MEM_LAT+2 cycles. Next grant no earlier than the cycle after RESP.
- Stores use identical timing. dm_rdata is not updated on a store and holds the last load value.
- rdata registers hold their value until the next completed read by the same owner.
- Priority on simultaneous IF/DM requests in IDLE: DM wins (older instruction). IF waits, with if_ready low.
- Requests are sampled only in IDLE. Changes to req, addr or data during ACCESS or RESP are ignored (protocol violation, no effect on the in-flight access).
- Request dropped before grant: no access issued.
- Reset mid-access: next state IDLE, mem_en/mem_we/ready drop at that edge, in-flight access abandoned, rdata registers cleared to 0. No ready is ever issued for the abandoned access.
- Addresses pass through unchanged; alignment is the requester's responsibility.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- When defined: a 4-bit starve counter increments on every DM grant made while if_req is also high, and clears on any IF grant. When it equals STARVE_MAX and both requests are high in IDLE, IF is granted and the counter clears.
- When undefined: strict DM priority; the counter is not built; STARVE_MAX is unused.

Test Plan:
1. MEM_LAT=2, reset, if_req=1, if_addr=0x00000010, memory returns 0x2008000A -> mem_en high one cycle with mem_addr=0x10; if_ready pulses 4 cycles after the grant cycle; if_rdata=0x2008000A; busy high from grant+1 through RESP.
2. if_req and dm_req both high in the same IDLE cycle, dm_addr=0x40, dm_we=0 -> DM served first with dm_ready and dm_rdata=mem[0x40]. IF is granted in the cycle after dm_ready and completes 4 cycles later.
3. Store dm_we=1, dm_addr=0x44, dm_wdata=0xDEADBEEF -> mem_we=1 only in the mem_en cycle with mem_wdata=0xDEADBEEF; dm_ready pulses; dm_rdata unchanged from the previous load.
4. Assert reset during ACCESS (cycle G+2) -> at the next edge all outputs are 0, FSM is IDLE, no ready pulse follows; a new if_req afterwards completes normally.
5. With ARB_STARVE_GUARD_EN defined and STARVE_MAX=4, if_req and dm_req held continuously -> grant order DM, DM, DM, DM, IF, DM, ...; without the macro, DM only while dm_req stays high.
6. MEM_LAT=1 and MEM_LAT=15 sweep, back-to-back IF fetches -> ready spacing of exactly MEM_LAT+3 cycles, data always matches memory content.
